// File: rtl/ps2_pkg.sv
// Shared types and helpers for the PS/2 host link (transmit side and receiver).
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        SEND,
        ACK,
        WAIT_IDLE,
        DONE,
        ERR
    } state_t;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_START = 2'b01;
    localparam logic [1:0] ERR_PKT   = 2'b10;
    localparam logic [1:0] ERR_NACK  = 2'b11;

    localparam int unsigned BIT_IDX_W  = 4;
    localparam int unsigned FRAME_BITS = 10;  // data[7:0], parity, stop

    function automatic logic odd_parity(input logic [7:0] data);
        return ~(^data);
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizers for the PS/2 pins plus a registered falling-edge strobe on clk.
module ps2_line_sync (
    input  logic clk,
    input  logic reset,
    input  logic ps2_clk_in,
    input  logic ps2_dat_in,
    output logic clk_s,
    output logic dat_s,
    output logic fall
);

    logic [1:0] clk_ff;
    logic [1:0] dat_ff;
    logic       clk_prev;

    // Lines idle high, so the synchronizers reset to 1 to avoid a spurious fall.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_ff   <= 2'b11;
            dat_ff   <= 2'b11;
            clk_prev <= 1'b1;
            fall     <= 1'b0;
        end else begin
            clk_ff   <= {clk_ff[0], ps2_clk_in};
            dat_ff   <= {dat_ff[0], ps2_dat_in};
            clk_prev <= clk_ff[1];
            fall     <= clk_prev & ~clk_ff[1];
        end
    end

    assign clk_s = clk_ff[1];
    assign dat_s = dat_ff[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, clocked-out frame, ack check, timeouts.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 6000,
    parameter int unsigned START_TIMEOUT  = 750000,
    parameter int unsigned PACKET_TIMEOUT = 100000,
    parameter int unsigned CNT_W          = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error,
    output logic [1:0] err_code
);

    localparam logic [CNT_W-1:0]     INH_LAST   = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0]     START_LAST = CNT_W'(START_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]     PKT_LAST   = CNT_W'(PACKET_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]     CNT_MAX    = '1;
    localparam logic [BIT_IDX_W-1:0] IDX_LAST   = BIT_IDX_W'(FRAME_BITS - 1);

    state_t                 state, state_n;
    logic [CNT_W-1:0]       cnt, cnt_n, cnt_inc;
    logic [BIT_IDX_W-1:0]   idx, idx_n;
    logic [FRAME_BITS-1:0]  shreg, shreg_n;
    logic [1:0]             fail_n, err_code_n;
    logic                   clk_oe_n, dat_oe_n, done_n, error_n, ready_n;
    logic                   clk_s, dat_s, fall;
    logic                   accept;

    ps2_line_sync u_sync (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk_in (ps2_clk_in),
        .ps2_dat_in (ps2_dat_in),
        .clk_s      (clk_s),
        .dat_s      (dat_s),
        .fall       (fall)
    );

    assign accept  = (state == IDLE) && tx_valid && tx_ready;
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            shreg      <= '0;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            tx_ready   <= 1'b1;
            busy       <= 1'b0;
            tx_done    <= 1'b0;
            tx_error   <= 1'b0;
            err_code   <= ERR_NONE;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            idx        <= idx_n;
            shreg      <= shreg_n;
            ps2_clk_oe <= clk_oe_n;
            ps2_dat_oe <= dat_oe_n;
            tx_ready   <= ready_n;
            busy       <= ~ready_n;
            tx_done    <= done_n;
            tx_error   <= error_n;
            err_code   <= err_code_n;
        end
    end

    // Timeout checks come before fall so an expiry in the same cycle wins.
    always_comb begin
        state_n = state;
        cnt_n   = cnt_inc;
        idx_n   = idx;
        shreg_n = shreg;
        fail_n  = ERR_NONE;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (accept) begin
                    state_n = INHIBIT;
                    shreg_n = {1'b1, odd_parity(tx_data), tx_data};
                end
            end
            INHIBIT: begin
                if (cnt == INH_LAST) begin
                    state_n = RTS;
                    cnt_n   = '0;
                end
            end
            RTS: begin
                if (cnt == START_LAST) begin
                    state_n = ERR;
                    fail_n  = ERR_START;
                end else if (fall) begin
                    state_n = SEND;
                    cnt_n   = '0;
                    idx_n   = '0;
                end
            end
            SEND: begin
                if (cnt == PKT_LAST) begin
                    state_n = ERR;
                    fail_n  = ERR_PKT;
                end else if (fall) begin
                    idx_n = idx + BIT_IDX_W'(1);
                    if (idx == IDX_LAST) state_n = ACK;
                end
            end
            ACK: begin
                if (cnt == PKT_LAST) begin
                    state_n = ERR;
                    fail_n  = ERR_PKT;
                end else if (fall) begin
                    if (dat_s) begin
                        state_n = ERR;
                        fail_n  = ERR_NACK;
                    end else begin
                        state_n = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                if (cnt == PKT_LAST) begin
                    state_n = ERR;
                    fail_n  = ERR_PKT;
                end else if (clk_s && dat_s) begin
                    state_n = DONE;
                end
            end
            DONE:    state_n = IDLE;
            ERR:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Next values of the registered outputs, derived from the upcoming state.
    always_comb begin
        clk_oe_n   = (state_n == INHIBIT);
        dat_oe_n   = 1'b0;
        done_n     = (state_n == DONE);
        error_n    = (state_n == ERR);
        ready_n    = (state_n == IDLE);
        err_code_n = err_code;
        case (state_n)
            INHIBIT: dat_oe_n = (cnt_n == INH_LAST);
            RTS:     dat_oe_n = 1'b1;
            SEND:    dat_oe_n = (state == SEND && fall) ? ~shreg[idx] : ps2_dat_oe;
            default: dat_oe_n = 1'b0;
        endcase
        if (accept) begin
            err_code_n = ERR_NONE;
        end else if (fail_n != ERR_NONE) begin
            err_code_n = fail_n;
        end
    end

endmodule
